// File: rtl/mem_access_unit_pkg.sv
// Shared widths, size codes, memory response codes and FSM state type for
// the memory access unit and its load-extension helper.
package mem_access_unit_pkg;

  // Bus geometry
  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  // Access size codes
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  // Peripheral response codes; INVALID doubles as "no response this cycle".
  // TIMEOUT is generated locally and never comes from the peripheral.
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_TIMEOUT       = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_load_extend.sv
// Combinational load-data extension: keeps the low byte/half/word of the
// right-aligned peripheral data and fills the upper bits with zeros or the
// sign bit of the accessed quantity.
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic                   sign_ext,
  input  logic [WORD_W-1:0]      rd_data,
  output logic [WORD_W-1:0]      data
);

  // Select the accessed width and extend it to a full word
  always_comb begin
    data = {WORD_W{1'b0}};
    case (count)
      MEM_COUNT_BYTE: data = {{(WORD_W-8){sign_ext & rd_data[7]}}, rd_data[7:0]};
      MEM_COUNT_HALF: data = {{(WORD_W-16){sign_ext & rd_data[15]}}, rd_data[15:0]};
      MEM_COUNT_WORD: data = rd_data;
      default:        data = {WORD_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one load/store op at a time, issues a single
// one-cycle request to a memory-mapped peripheral, waits for its registered
// response and returns the extended load data plus the final memory code.
// Optional feature macro: MEM_TIMEOUT_EN (abort WAIT after TIMEOUT_CYCLES).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  logic [ADDR_W-1:0]      i_op_addr,
  input  logic [WORD_W-1:0]      i_op_wr_data,
  input  logic                   i_op_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_op_count,
  input  logic                   i_op_signed,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [WORD_W-1:0]      o_res_data,
  output logic [MEM_CODE_W-1:0]  o_res_code,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  mau_state_e             state_r;
  mau_state_e             state_next_s;
  logic                   accept_s;
  logic                   capture_s;
  logic                   timeout_s;
  logic                   timeout_hit_s;
  logic [MEM_COUNT_W-1:0] op_count_r;
  logic                   op_signed_r;
  logic [WORD_W-1:0]      ext_data_s;

  mem_load_extend u_load_extend (
    .count    (op_count_r),
    .sign_ext (op_signed_r),
    .rd_data  (i_res_rd_data),
    .data     (ext_data_s)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_r;

  assign timeout_hit_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter: cleared in REQ so it starts at zero on entry to WAIT
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  // Without the timeout feature WAIT never expires
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign timeout_hit_s    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and one-cycle event strobes for the output registers
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_op_valid && o_op_ready) begin
          accept_s     = 1'b1;
          state_next_s = (i_op_count == MEM_COUNT_NONE) ? ST_RESP : ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_res_code != MEM_CODE_INVALID) begin
          capture_s    = 1'b1;
          state_next_s = ST_RESP;
        end else if (timeout_hit_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (i_res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: ready, one-cycle downstream request, op latches, result
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      o_op_ready    <= 1'b0;
      o_req_addr    <= {ADDR_W{1'b0}};
      o_req_wr_data <= {WORD_W{1'b0}};
      o_req_wr_en   <= 1'b0;
      o_req_count   <= MEM_COUNT_NONE;
      op_count_r    <= MEM_COUNT_NONE;
      op_signed_r   <= 1'b0;
      o_res_valid   <= 1'b0;
      o_res_data    <= {WORD_W{1'b0}};
      o_res_code    <= MEM_CODE_INVALID;
    end else begin
      o_op_ready <= (state_next_s == ST_IDLE);

      // The request is only ever presented during the single REQ cycle
      if (accept_s && (i_op_count != MEM_COUNT_NONE)) begin
        o_req_addr    <= i_op_addr;
        o_req_wr_data <= i_op_wr_data;
        o_req_wr_en   <= i_op_wr_en;
        o_req_count   <= i_op_count;
      end else begin
        o_req_addr    <= {ADDR_W{1'b0}};
        o_req_wr_data <= {WORD_W{1'b0}};
        o_req_wr_en   <= 1'b0;
        o_req_count   <= MEM_COUNT_NONE;
      end

      if (accept_s) begin
        op_count_r  <= i_op_count;
        op_signed_r <= i_op_signed;
      end else begin
        op_count_r  <= op_count_r;
        op_signed_r <= op_signed_r;
      end

      if (accept_s && (i_op_count == MEM_COUNT_NONE)) begin
        o_res_valid <= 1'b1;
        o_res_data  <= {WORD_W{1'b0}};
        o_res_code  <= MEM_CODE_INVALID;
      end else if (capture_s) begin
        o_res_valid <= 1'b1;
        o_res_data  <= (i_res_code == MEM_CODE_READ) ? ext_data_s : {WORD_W{1'b0}};
        o_res_code  <= i_res_code;
      end else if (timeout_s) begin
        o_res_valid <= 1'b1;
        o_res_data  <= {WORD_W{1'b0}};
        o_res_code  <= MEM_CODE_TIMEOUT;
      end else if ((state_r == ST_RESP) && i_res_ready) begin
        o_res_valid <= 1'b0;
        o_res_data  <= {WORD_W{1'b0}};
        o_res_code  <= MEM_CODE_INVALID;
      end else begin
        o_res_valid <= o_res_valid;
        o_res_data  <= o_res_data;
        o_res_code  <= o_res_code;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a small registered peripheral
// model with a 16-word memory, a vector table driven through a scoreboard,
// and hand-written sequences for latency, stall, stray-response and reset.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   i_op_valid = 1'b0;
  logic                   o_op_ready;
  logic [ADDR_W-1:0]      i_op_addr = 32'd0;
  logic [WORD_W-1:0]      i_op_wr_data = 32'd0;
  logic                   i_op_wr_en = 1'b0;
  logic [MEM_COUNT_W-1:0] i_op_count = MEM_COUNT_NONE;
  logic                   i_op_signed = 1'b0;
  logic                   o_res_valid;
  logic                   i_res_ready = 1'b1;
  logic [WORD_W-1:0]      o_res_data;
  logic [MEM_CODE_W-1:0]  o_res_code;
  logic [ADDR_W-1:0]      o_req_addr;
  logic [WORD_W-1:0]      o_req_wr_data;
  logic                   o_req_wr_en;
  logic [MEM_COUNT_W-1:0] o_req_count;
  logic [WORD_W-1:0]      i_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_res_code;

  int total = 0;
  int bad = 0;

  // Peripheral model controls and activity counters
  logic        silent = 1'b0;
  logic        stray = 1'b0;
  int          req_cycles = 0;
  int          wr_cycles = 0;
  logic [31:0] mem [0:15];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  cnt;
    logic        sgn;
    logic [31:0] exp_data;
    logic [2:0]  exp_code;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  c;
  } exp_t;

  vec_t vecs [0:18];
  exp_t sb_q [$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .i_op_valid    (i_op_valid),
    .o_op_ready    (o_op_ready),
    .i_op_addr     (i_op_addr),
    .i_op_wr_data  (i_op_wr_data),
    .i_op_wr_en    (i_op_wr_en),
    .i_op_count    (i_op_count),
    .i_op_signed   (i_op_signed),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready),
    .o_res_data    (o_res_data),
    .o_res_code    (o_res_code),
    .o_req_addr    (o_req_addr),
    .o_req_wr_data (o_req_wr_data),
    .o_req_wr_en   (o_req_wr_en),
    .o_req_count   (o_req_count),
    .i_res_rd_data (i_res_rd_data),
    .i_res_code    (i_res_code)
  );

  always #5 clk = ~clk;

  // Registered peripheral: little-endian memory, right-aligned read data
  always @(posedge clk) begin
    if (!aresetn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h1111_2222;
      mem[1] <= 32'h8000_00F0;
      i_res_code    <= MEM_CODE_INVALID;
      i_res_rd_data <= 32'd0;
    end else begin
      i_res_code    <= MEM_CODE_INVALID;
      i_res_rd_data <= 32'hDEAD_BEEF;
      if (o_req_count != MEM_COUNT_NONE) begin
        req_cycles <= req_cycles + 1;
        if (o_req_wr_en) wr_cycles <= wr_cycles + 1;
      end
      if (stray) begin
        i_res_code    <= MEM_CODE_READ;
        i_res_rd_data <= 32'h0BAD_0BAD;
      end else if (!silent && o_req_count != MEM_COUNT_NONE) begin
        if (o_req_addr >= 32'd64) begin
          i_res_code <= MEM_CODE_OUT_OF_BOUNDS;
        end else if ((o_req_count == MEM_COUNT_HALF && o_req_addr[0]) ||
                     (o_req_count == MEM_COUNT_WORD && o_req_addr[1:0] != 2'b00)) begin
          i_res_code <= MEM_CODE_MISALIGNED;
        end else if (o_req_wr_en) begin
          i_res_code <= MEM_CODE_WRITE;
          case (o_req_count)
            MEM_COUNT_BYTE: mem[o_req_addr[5:2]][{o_req_addr[1:0], 3'b000} +: 8] <= o_req_wr_data[7:0];
            MEM_COUNT_HALF: mem[o_req_addr[5:2]][{o_req_addr[1], 4'b0000} +: 16] <= o_req_wr_data[15:0];
            default:        mem[o_req_addr[5:2]] <= o_req_wr_data;
          endcase
        end else begin
          i_res_code    <= MEM_CODE_READ;
          i_res_rd_data <= mem[o_req_addr[5:2]] >> {o_req_addr[1:0], 3'b000};
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_op(input vec_t v);
    i_op_valid   = 1'b1;
    i_op_wr_en   = v.wr;
    i_op_addr    = v.addr;
    i_op_wr_data = v.wdata;
    i_op_count   = v.cnt;
    i_op_signed  = v.sgn;
  endtask

  // Apply one vector: accept, push expectation, pop and compare on result
  task automatic apply_op(input int idx);
    vec_t v;
    exp_t e;
    int   req0, wr0;
    bit   ok;
    v    = vecs[idx];
    req0 = req_cycles;
    wr0  = wr_cycles;
    @(negedge clk);
    drive_op(v);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_op_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept[%0d]: got no ready want ready", idx);
      i_op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    sb_q.push_back('{d: v.exp_data, c: v.exp_code});
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_res_valid) begin ok = 1'b1; break; end
    end
    e = sb_q.pop_front();
    if (!ok) begin
      total++; bad++;
      $display("FAIL result[%0d]: got no valid want valid", idx);
      return;
    end
    check($sformatf("data[%0d]", idx), o_res_data, e.d);
    check($sformatf("code[%0d]", idx), 32'(o_res_code), 32'(e.c));
    @(posedge clk);
    #1;
    check($sformatf("reqs[%0d]", idx), req_cycles - req0, (v.cnt != MEM_COUNT_NONE) ? 1 : 0);
    check($sformatf("wrs[%0d]", idx), wr_cycles - wr0, (v.wr && v.cnt != MEM_COUNT_NONE) ? 1 : 0);
  endtask

  initial begin
    int   req0;
    bit   seen;
    vec_t v;

    vecs[0]  = '{1'b0, 32'h4,   32'h0,         MEM_COUNT_WORD, 1'b0, 32'h8000_00F0, MEM_CODE_READ};
    vecs[1]  = '{1'b0, 32'h4,   32'h0,         MEM_COUNT_WORD, 1'b1, 32'h8000_00F0, MEM_CODE_READ};
    vecs[2]  = '{1'b1, 32'h4,   32'h80FF_1234, MEM_COUNT_WORD, 1'b0, 32'h0,         MEM_CODE_WRITE};
    vecs[3]  = '{1'b0, 32'h7,   32'h0,         MEM_COUNT_BYTE, 1'b1, 32'hFFFF_FF80, MEM_CODE_READ};
    vecs[4]  = '{1'b0, 32'h7,   32'h0,         MEM_COUNT_BYTE, 1'b0, 32'h0000_0080, MEM_CODE_READ};
    vecs[5]  = '{1'b0, 32'h4,   32'h0,         MEM_COUNT_BYTE, 1'b1, 32'h0000_0034, MEM_CODE_READ};
    vecs[6]  = '{1'b0, 32'h6,   32'h0,         MEM_COUNT_HALF, 1'b1, 32'hFFFF_80FF, MEM_CODE_READ};
    vecs[7]  = '{1'b0, 32'h6,   32'h0,         MEM_COUNT_HALF, 1'b0, 32'h0000_80FF, MEM_CODE_READ};
    vecs[8]  = '{1'b0, 32'h4,   32'h0,         MEM_COUNT_HALF, 1'b1, 32'h0000_1234, MEM_CODE_READ};
    vecs[9]  = '{1'b1, 32'h2,   32'h0000_BEEF, MEM_COUNT_HALF, 1'b0, 32'h0,         MEM_CODE_WRITE};
    vecs[10] = '{1'b0, 32'h0,   32'h0,         MEM_COUNT_WORD, 1'b0, 32'hBEEF_2222, MEM_CODE_READ};
    vecs[11] = '{1'b0, 32'h1,   32'h0,         MEM_COUNT_WORD, 1'b0, 32'h0,         MEM_CODE_MISALIGNED};
    vecs[12] = '{1'b0, 32'h5,   32'h0,         MEM_COUNT_HALF, 1'b1, 32'h0,         MEM_CODE_MISALIGNED};
    vecs[13] = '{1'b0, 32'h100, 32'h0,         MEM_COUNT_WORD, 1'b0, 32'h0,         MEM_CODE_OUT_OF_BOUNDS};
    vecs[14] = '{1'b1, 32'h5,   32'hFFFF_FFAB, MEM_COUNT_BYTE, 1'b0, 32'h0,         MEM_CODE_WRITE};
    vecs[15] = '{1'b0, 32'h4,   32'h0,         MEM_COUNT_WORD, 1'b0, 32'h80FF_AB34, MEM_CODE_READ};
    vecs[16] = '{1'b1, 32'h2,   32'h1234_5678, MEM_COUNT_WORD, 1'b0, 32'h0,         MEM_CODE_MISALIGNED};
    vecs[17] = '{1'b0, 32'h8,   32'h0,         MEM_COUNT_NONE, 1'b1, 32'h0,         MEM_CODE_INVALID};
    vecs[18] = '{1'b1, 32'h8,   32'h5555_5555, MEM_COUNT_NONE, 1'b0, 32'h0,         MEM_CODE_INVALID};

    // Reset state while aresetn is held low
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_op_ready), 32'd0);
    check("rst_valid", 32'(o_res_valid), 32'd0);
    check("rst_count", 32'(o_req_count), 32'(MEM_COUNT_NONE));
    check("rst_code",  32'(o_res_code), 32'd0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk);
    #1 check("rel_ready", 32'(o_op_ready), 32'd1);

    // Word load latency: REQ in N+1, result valid in N+3
    @(negedge clk);
    drive_op(vecs[0]);
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    check("lat_req_count", 32'(o_req_count), 32'(MEM_COUNT_WORD));
    check("lat_req_addr",  o_req_addr, 32'h4);
    check("lat_busy",      32'(o_op_ready), 32'd0);
    @(posedge clk);
    #1;
    check("lat_req_drop",  32'(o_req_count), 32'(MEM_COUNT_NONE));
    check("lat_early",     32'(o_res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid",     32'(o_res_valid), 32'd1);
    check("lat_data",      o_res_data, 32'h8000_00F0);
    check("lat_code",      32'(o_res_code), 32'(MEM_CODE_READ));
    @(posedge clk);
    #1;
    check("lat_done",      32'(o_res_valid), 32'd0);
    check("lat_idle",      32'(o_op_ready), 32'd1);

    // Count NONE: result the cycle after accept, no downstream request
    req0 = req_cycles;
    @(negedge clk);
    drive_op(vecs[17]);
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    check("none_valid", 32'(o_res_valid), 32'd1);
    check("none_code",  32'(o_res_code), 32'(MEM_CODE_INVALID));
    check("none_req",   32'(o_req_count), 32'(MEM_COUNT_NONE));
    @(posedge clk);
    #1 check("none_noreq", req_cycles - req0, 0);

    // Table-driven vectors
    for (int i = 0; i < 19; i++) apply_op(i);

    // Result stall: outputs stable and no new op while i_res_ready is low
    i_res_ready = 1'b0;
    @(negedge clk);
    drive_op(vecs[5]);
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(o_res_valid), 32'd1);
      check("stall_data",  o_res_data, 32'h0000_0034);
      check("stall_ready", 32'(o_op_ready), 32'd0);
    end
    i_res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", 32'(o_res_valid), 32'd0);
    check("stall_idle",    32'(o_op_ready), 32'd1);

    // Stray responses while idle are ignored
    @(negedge clk) stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_valid", 32'(o_res_valid), 32'd0);
      check("stray_ready", 32'(o_op_ready), 32'd1);
    end
    stray = 1'b0;
    repeat (2) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    // Silent peripheral: TIMEOUT after four WAIT cycles, late response ignored
    silent = 1'b1;
    i_res_ready = 1'b0;
    @(negedge clk);
    drive_op(vecs[0]);
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("to_early", 32'(o_res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("to_valid", 32'(o_res_valid), 32'd1);
    check("to_code",  32'(o_res_code), 32'(MEM_CODE_TIMEOUT));
    check("to_data",  o_res_data, 32'd0);
    stray = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("to_late", 32'(o_res_code), 32'(MEM_CODE_TIMEOUT));
    stray = 1'b0;
    silent = 1'b0;
    i_res_ready = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
`endif

    // Silent peripheral: WAIT holds, then reset drops the op
    silent = 1'b1;
    @(negedge clk);
    drive_op(vecs[0]);
    @(posedge clk);
    #1 i_op_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_res_valid) seen = 1'b1;
    end
`ifndef MEM_TIMEOUT_EN
    check("wait_forever", 32'(seen), 32'd0);
`endif
    aresetn = 1'b0;
    #1;
    check("arst_ready", 32'(o_op_ready), 32'd0);
    check("arst_valid", 32'(o_res_valid), 32'd0);
    silent = 1'b0;
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk);
    #1;
    check("arst_idle",  32'(o_op_ready), 32'd1);
    check("arst_noresp", 32'(o_res_valid), 32'd0);
    v = vecs[0];
    v.wr = v.wr;
    apply_op(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
